conv_fc_seq_engine: RTL and testbench

//  Parametrised, time-multiplexed conv(KxK, 1 channel) + bias + FC(N_CLS) inference engine.

---
 rtl/conv_fc_seq_engine_if.sv | 34 +++
 rtl/conv_fc_seq_engine.sv | 144 ++++++++++++++
 tb/tb_conv_fc_seq_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_fc_seq_engine_if.sv
// Job/result bundle for conv_fc_seq_engine: request/response handshakes, live operand arrays, class scores.
// master = job producer and result consumer, slave = the engine.
interface conv_fc_seq_engine_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int N_CLS = 10,
  parameter int DW    = 8,
  parameter int ACC_W = 32
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int NPIX  = OUT_W * OUT_H;

  logic                    pre_valid;
  logic                    pre_ready;
  logic                    post_valid;
  logic                    post_ready;
  logic        [DW-1:0]    data        [IMG_H][IMG_W];
  logic signed [DW-1:0]    conv_weight [K*K];
  logic signed [DW-1:0]    conv_bias;
  logic signed [DW-1:0]    fc_weight   [N_CLS][NPIX];
  logic signed [ACC_W-1:0] res         [N_CLS];

  modport master (
    output pre_valid, post_ready, data, conv_weight, conv_bias, fc_weight,
    input  pre_ready, post_valid, res
  );

  modport slave (
    input  pre_valid, post_ready, data, conv_weight, conv_bias, fc_weight,
    output pre_ready, post_valid, res
  );
endinterface

// File: rtl/conv_fc_seq_engine.sv
// Time-multiplexed KxK conv + bias + N_CLS-way FC: one conv MAC, N_CLS parallel FC MACs.
// Optional `define CONV_RELU_EN clamps negative conv results to zero before the FC stage.
module conv_fc_seq_engine #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int N_CLS = 10,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input logic                clk,
  input logic                rst,
  conv_fc_seq_engine_if.slave bus
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int KK    = K * K;
  localparam int CW    = 2 * DW + 1 + $clog2(KK);
  localparam int TW    = 2 * DW + 1;
  localparam int PW    = CW + DW;
  localparam int HW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int KIW   = (KK > 1) ? $clog2(KK) : 1;
  localparam int PIXW  = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {IDLE, CONV, FC, DONE} state_t;

  state_t                  state, state_next;
  logic [HW-1:0]           r, kr;
  logic [WW-1:0]           c, kc;
  logic [KIW-1:0]          k;
  logic [PIXW-1:0]         pix;
  logic signed [CW-1:0]    conv_sum;
  logic signed [CW-1:0]    conv_out;
  logic signed [TW-1:0]    conv_term;
  logic signed [PW-1:0]    fc_prod [N_CLS];
  logic signed [ACC_W-1:0] acc     [N_CLS];
  logic                    last_tap;
  logic                    last_pix;

  assign last_tap = (k == KIW'(KK - 1));
  assign last_pix = (pix == PIXW'(NPIX - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_next     = state;
    bus.pre_ready  = 1'b0;
    bus.post_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.pre_ready = 1'b1;
        if (bus.pre_valid) state_next = CONV;
      end
      CONV:    if (last_tap) state_next = FC;
      FC:      state_next = last_pix ? DONE : CONV;
      DONE: begin
        bus.post_valid = 1'b1;
        if (bus.post_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel is zero-extended into a signed operand so the product stays signed.
  always_comb begin
    conv_term = TW'(signed'({1'b0, bus.data[r + kr][c + kc]})) * TW'(bus.conv_weight[k]);
`ifdef CONV_RELU_EN
    conv_out = conv_sum[CW-1] ? '0 : conv_sum;
`else
    conv_out = conv_sum;
`endif
    for (int n = 0; n < N_CLS; n++) begin
      fc_prod[n] = PW'(conv_out) * PW'(bus.fc_weight[n][pix]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= '0;
      c        <= '0;
      kr       <= '0;
      kc       <= '0;
      k        <= '0;
      pix      <= '0;
      conv_sum <= '0;
      // NOTE: acc is a small flop array, not a RAM, so it is reset: o_res must read zero straight after reset.
      for (int n = 0; n < N_CLS; n++) acc[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pre_valid) begin
            r        <= '0;
            c        <= '0;
            kr       <= '0;
            kc       <= '0;
            k        <= '0;
            pix      <= '0;
            conv_sum <= CW'(bus.conv_bias);
            for (int n = 0; n < N_CLS; n++) acc[n] <= '0;
          end
        end
        CONV: begin
          conv_sum <= conv_sum + CW'(conv_term);
          k        <= k + 1'b1;
          if (kc == WW'(K - 1)) begin
            kc <= '0;
            kr <= kr + 1'b1;
          end else begin
            kc <= kc + 1'b1;
          end
        end
        FC: begin
          // Products are truncated or sign-extended to ACC_W; accumulation wraps.
          for (int n = 0; n < N_CLS; n++) acc[n] <= acc[n] + ACC_W'(fc_prod[n]);
          if (!last_pix) begin
            pix      <= pix + 1'b1;
            k        <= '0;
            kr       <= '0;
            kc       <= '0;
            conv_sum <= CW'(bus.conv_bias);
            if (c == WW'(OUT_W - 1)) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < N_CLS; n++) bus.res[n] = acc[n];
  end
endmodule

// File: tb/tb_conv_fc_seq_engine.sv
// Scoreboard bench for conv_fc_seq_engine: a default-size engine and a 4x4 wrap-around engine.
// Expected scores come from a direct reference model pushed at job start and popped at o_post_valid.
module tb_conv_fc_seq_engine;
  localparam int A_W = 28, A_H = 28, A_K = 3, A_N = 10, A_ACC = 32;
  localparam int A_OW = A_W - A_K + 1;
  localparam int A_NPIX = A_OW * (A_H - A_K + 1);
  localparam int A_LAT = A_NPIX * (A_K * A_K + 1) + 1;
  localparam int B_W = 4, B_H = 4, B_K = 3, B_N = 2, B_ACC = 8;
  localparam int B_OW = B_W - B_K + 1;
  localparam int B_NPIX = B_OW * (B_H - B_K + 1);
  localparam int B_LAT = B_NPIX * (B_K * B_K + 1) + 1;
`ifdef CONV_RELU_EN
  localparam longint T3_EXP = 0;
`else
  localparam longint T3_EXP = -12168;
`endif

  typedef logic [A_N-1:0][A_ACC-1:0] exp_a_t;
  typedef logic [B_N-1:0][B_ACC-1:0] exp_b_t;

  logic   clk = 1'b0;
  logic   rst;
  int     checks = 0;
  int     failures = 0;
  exp_a_t sb_a[$];
  exp_b_t sb_b[$];

  logic        [7:0] img_a [A_H][A_W];
  logic signed [7:0] cw_a  [A_K*A_K];
  logic signed [7:0] bias_a;
  logic signed [7:0] fw_a  [A_N][A_NPIX];
  logic        [7:0] img_b [B_H][B_W];
  logic signed [7:0] cw_b  [B_K*B_K];
  logic signed [7:0] bias_b;
  logic signed [7:0] fw_b  [B_N][B_NPIX];

  conv_fc_seq_engine_if #(.IMG_W(A_W), .IMG_H(A_H), .K(A_K), .N_CLS(A_N), .DW(8), .ACC_W(A_ACC)) bus_a ();
  conv_fc_seq_engine_if #(.IMG_W(B_W), .IMG_H(B_H), .K(B_K), .N_CLS(B_N), .DW(8), .ACC_W(B_ACC)) bus_b ();

  conv_fc_seq_engine #(.IMG_W(A_W), .IMG_H(A_H), .K(A_K), .N_CLS(A_N), .DW(8), .ACC_W(A_ACC)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  conv_fc_seq_engine #(.IMG_W(B_W), .IMG_H(B_H), .K(B_K), .N_CLS(B_N), .DW(8), .ACC_W(B_ACC)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_a(input int pix_v, input int cw_v, input int bias_v, input bit by_class, input int fw_v);
    for (int r = 0; r < A_H; r++) for (int c = 0; c < A_W; c++) img_a[r][c] = 8'(pix_v);
    for (int i = 0; i < A_K * A_K; i++) cw_a[i] = 8'(cw_v);
    bias_a = 8'(bias_v);
    for (int n = 0; n < A_N; n++) for (int p = 0; p < A_NPIX; p++) fw_a[n][p] = by_class ? 8'(n) : 8'(fw_v);
    bus_a.data = img_a;
    bus_a.conv_weight = cw_a;
    bus_a.conv_bias = bias_a;
    bus_a.fc_weight = fw_a;
  endtask

  task automatic fill_b(input bit rnd, input int pix_v, input int w_v);
    for (int r = 0; r < B_H; r++) for (int c = 0; c < B_W; c++) img_b[r][c] = rnd ? 8'($urandom) : 8'(pix_v);
    for (int i = 0; i < B_K * B_K; i++) cw_b[i] = rnd ? 8'($urandom) : 8'(w_v);
    bias_b = rnd ? 8'($urandom) : 8'(w_v);
    for (int n = 0; n < B_N; n++) for (int p = 0; p < B_NPIX; p++) fw_b[n][p] = rnd ? 8'($urandom) : 8'(w_v);
    bus_b.data = img_b;
    bus_b.conv_weight = cw_b;
    bus_b.conv_bias = bias_b;
    bus_b.fc_weight = fw_b;
  endtask

  function automatic exp_a_t model_a();
    longint acc [A_N];
    longint s;
    exp_a_t e;
    for (int n = 0; n < A_N; n++) acc[n] = 0;
    for (int r = 0; r <= A_H - A_K; r++) begin
      for (int c = 0; c < A_OW; c++) begin
        s = longint'(bias_a);
        for (int kr = 0; kr < A_K; kr++)
          for (int kc = 0; kc < A_K; kc++)
            s += longint'(img_a[r+kr][c+kc]) * longint'(cw_a[kr*A_K+kc]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        for (int n = 0; n < A_N; n++) acc[n] += s * longint'(fw_a[n][r*A_OW+c]);
      end
    end
    for (int n = 0; n < A_N; n++) e[n] = A_ACC'(acc[n]);
    return e;
  endfunction

  function automatic exp_b_t model_b();
    longint acc [B_N];
    longint s;
    exp_b_t e;
    for (int n = 0; n < B_N; n++) acc[n] = 0;
    for (int r = 0; r <= B_H - B_K; r++) begin
      for (int c = 0; c < B_OW; c++) begin
        s = longint'(bias_b);
        for (int kr = 0; kr < B_K; kr++)
          for (int kc = 0; kc < B_K; kc++)
            s += longint'(img_b[r+kr][c+kc]) * longint'(cw_b[kr*B_K+kc]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        for (int n = 0; n < B_N; n++) acc[n] += s * longint'(fw_b[n][r*B_OW+c]);
      end
    end
    // Full-precision sum reduced mod 2^ACC_W once at the end.
    for (int n = 0; n < B_N; n++) e[n] = B_ACC'(acc[n]);
    return e;
  endfunction

  // Starts and ends on a falling edge; returns on the IDLE cycle after the result handshake.
  task automatic job_a(input string tag, input int hold, input bit keep_valid);
    exp_a_t e;
    int cyc;
    sb_a.push_back(model_a());
    bus_a.pre_valid = 1'b1;
    cyc = 0;
    while (!bus_a.pre_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check({tag, "_accept"}, bus_a.pre_ready, 1);
    @(negedge clk);
    cyc = 1;
    if (!keep_valid) bus_a.pre_valid = 1'b0;
    check({tag, "_busy_ready"}, bus_a.pre_ready, 0);
    while (!bus_a.post_valid && cyc < A_LAT + 20) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, cyc, A_LAT);
    e = sb_a.pop_front();
    for (int h = 0; h <= hold; h++) begin
      for (int n = 0; n < A_N; n++) check($sformatf("%s_res%0d_h%0d", tag, n, h), bus_a.res[n], signed'(e[n]));
      check({tag, "_done_valid"}, bus_a.post_valid, 1);
      check({tag, "_done_ready"}, bus_a.pre_ready, 0);
      if (h < hold) @(negedge clk);
    end
    bus_a.post_ready = 1'b1;
    @(negedge clk);
    bus_a.post_ready = 1'b0;
    check({tag, "_idle_ready"}, bus_a.pre_ready, 1);
    check({tag, "_idle_valid"}, bus_a.post_valid, 0);
  endtask

  task automatic job_b(input string tag);
    exp_b_t e;
    int cyc;
    sb_b.push_back(model_b());
    bus_b.pre_valid = 1'b1;
    cyc = 0;
    while (!bus_b.pre_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check({tag, "_accept"}, bus_b.pre_ready, 1);
    @(negedge clk);
    cyc = 1;
    bus_b.pre_valid = 1'b0;
    while (!bus_b.post_valid && cyc < B_LAT + 20) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, cyc, B_LAT);
    e = sb_b.pop_front();
    for (int n = 0; n < B_N; n++) check($sformatf("%s_res%0d", tag, n), bus_b.res[n], signed'(e[n]));
    bus_b.post_ready = 1'b1;
    @(negedge clk);
    bus_b.post_ready = 1'b0;
    check({tag, "_idle_ready"}, bus_b.pre_ready, 1);
    check({tag, "_idle_valid"}, bus_b.post_valid, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus_a.pre_valid = 1'b0;
    bus_a.post_ready = 1'b0;
    bus_b.pre_valid = 1'b0;
    bus_b.post_ready = 1'b0;
    fill_a(0, 0, 0, 1'b0, 0);
    fill_b(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", bus_a.pre_ready, 1);
    check("rst_valid", bus_a.post_valid, 0);
    for (int n = 0; n < A_N; n++) check($sformatf("rst_res%0d", n), bus_a.res[n], 0);
    check("rst_b_ready", bus_b.pre_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    fill_a(0, 0, 5, 1'b0, 1);
    job_a("t1", 0, 1'b0);
    check("t1_res0_abs", bus_a.res[0], 3380);

    fill_a(1, 1, 0, 1'b1, 0);
    job_a("t2", 0, 1'b0);
    check("t2_res9_abs", bus_a.res[9], 54756);

    fill_a(2, -1, 0, 1'b0, 1);
    job_a("t3", 0, 1'b0);
    check("t3_res0_abs", bus_a.res[0], T3_EXP);

    fill_a(1, 1, 0, 1'b1, 0);
    job_a("t4a", 20, 1'b1);
    job_a("t4b", 0, 1'b0);

    fill_a(0, 0, 5, 1'b0, 1);
    bus_a.pre_valid = 1'b1;
    cyc = 0;
    while (!bus_a.pre_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("t5_accept", bus_a.pre_ready, 1);
    @(negedge clk);
    bus_a.pre_valid = 1'b0;
    repeat (999) @(negedge clk);
    check("t5_midjob_valid", bus_a.post_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_abort_ready", bus_a.pre_ready, 1);
    check("t5_abort_valid", bus_a.post_valid, 0);
    for (int n = 0; n < A_N; n++) check($sformatf("t5_abort_res%0d", n), bus_a.res[n], 0);
    fill_a(1, 1, 0, 1'b1, 0);
    job_a("t5_rerun", 0, 1'b0);
    check("t5_res9_abs", bus_a.res[9], 54756);

    fill_b(1'b0, 255, 127);
    job_b("t6_wrap");
    for (int i = 0; i < 3; i++) begin
      fill_b(1'b1, 0, 0);
      job_b($sformatf("t6_rand%0d", i));
    end

    check("sb_empty", sb_a.size() + sb_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
